// File: rtl/iter_chunk_mult.sv
// Sequential integer multiplier: IN2 is consumed CHUNK bits per cycle and one
// shifted partial product IN1_mag*digit is accumulated each edge; signed mode uses sign-magnitude.
module iter_chunk_mult #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     IN1,
    input  logic [WIDTH-1:0]     IN2,
    input  logic                 SIGNED_MODE,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [2*WIDTH-1:0]   OUTPUT,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 BUSY,
    output logic [1:0]           state_dbg
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int KW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("iter_chunk_mult: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // Handshakes: a transfer happens on an edge where valid && ready are both high;
    // valid never depends combinationally on ready, and OUT_VALID/OUTPUT hold until taken.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic                   neg;
    logic [2*WIDTH-1:0]     acc;
    logic [KW-1:0]          k;

    logic                   accept;
    logic                   last_digit;
    logic                   in1_neg;
    logic                   in2_neg;
    logic [WIDTH-1:0]       in1_mag;
    logic [WIDTH-1:0]       in2_mag;
    logic [CHUNK-1:0]       digit;
    logic [WIDTH+CHUNK-1:0] pp;
    logic [2*WIDTH-1:0]     pp_ext;
    logic [2*WIDTH-1:0]     acc_sum;
    logic [2*WIDTH-1:0]     result;

    assign accept     = IN_VALID && IN_READY;
    assign last_digit = (k == KW'(NUM_CHUNKS - 1));

    // Magnitudes only in signed mode; -2^(WIDTH-1) maps to 2^(WIDTH-1), still WIDTH bits.
    assign in1_neg = SIGNED_MODE & IN1[WIDTH-1];
    assign in2_neg = SIGNED_MODE & IN2[WIDTH-1];
    assign in1_mag = in1_neg ? (~IN1 + WIDTH'(1)) : IN1;
    assign in2_mag = in2_neg ? (~IN2 + WIDTH'(1)) : IN2;

    // The single narrow WIDTH x CHUNK multiplier shared across all digits.
    assign digit = b_mag[int'(k)*CHUNK +: CHUNK];
    assign pp    = {{CHUNK{1'b0}}, a_mag} * {{WIDTH{1'b0}}, digit};

    always_comb begin
        pp_ext                    = '0;
        pp_ext[WIDTH+CHUNK-1:0]   = pp;
        acc_sum                   = acc + (pp_ext << (int'(k) * CHUNK));
        result                    = neg ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)     state_nxt = S_CALC;
            S_CALC:  if (last_digit) state_nxt = S_DONE;
            S_DONE:  if (OUT_READY)  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state == S_IDLE);
        OUT_VALID = (state == S_DONE);
        BUSY      = (state != S_IDLE);
        state_dbg = state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_mag  <= '0;
            b_mag  <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            k      <= '0;
            OUTPUT <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_mag <= in1_mag;
                        b_mag <= in2_mag;
                        neg   <= SIGNED_MODE & (IN1[WIDTH-1] ^ IN2[WIDTH-1]);
                        acc   <= '0;
                        k     <= '0;
                    end
                end
                S_CALC: begin
                    acc <= acc_sum;
                    if (last_digit) begin
                        // k returns to 0 so the digit select stays in range while idle.
                        k      <= '0;
                        OUTPUT <= result;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_chunk_mult.sv
// Bench for iter_chunk_mult: three configurations (32/8, 16/4, 24/24) driven in
// parallel, expected products queued at accept and popped by a monitor on output handshakes.
module tb_iter_chunk_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- signals
  int          cw[3] = '{32, 16, 24};
  int          nc[3] = '{4, 4, 1};
  logic        rst[3];
  logic        iv[3];
  logic        sm[3];
  logic        ordy[3];
  logic [31:0] in1[3];
  logic [31:0] in2[3];
  logic [2:0]  ir, ov, bz;
  logic [63:0] p32;
  logic [31:0] p16;
  logic [47:0] p24;
  logic [1:0]  st0, st1, st2;
  logic [63:0] prod[3];

  always_comb begin
    prod[0] = p32;
    prod[1] = {32'd0, p16};
    prod[2] = {16'd0, p24};
  end

  iter_chunk_mult #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .CLK(clk), .RST(rst[0]), .IN1(in1[0]), .IN2(in2[0]), .SIGNED_MODE(sm[0]),
    .IN_VALID(iv[0]), .IN_READY(ir[0]), .OUTPUT(p32), .OUT_VALID(ov[0]),
    .OUT_READY(ordy[0]), .BUSY(bz[0]), .state_dbg(st0));

  iter_chunk_mult #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .CLK(clk), .RST(rst[1]), .IN1(in1[1][15:0]), .IN2(in2[1][15:0]), .SIGNED_MODE(sm[1]),
    .IN_VALID(iv[1]), .IN_READY(ir[1]), .OUTPUT(p16), .OUT_VALID(ov[1]),
    .OUT_READY(ordy[1]), .BUSY(bz[1]), .state_dbg(st1));

  iter_chunk_mult #(.WIDTH(24), .CHUNK(24)) u_w24 (
    .CLK(clk), .RST(rst[2]), .IN1(in1[2][23:0]), .IN2(in2[2][23:0]), .SIGNED_MODE(sm[2]),
    .IN_VALID(iv[2]), .IN_READY(ir[2]), .OUTPUT(p24), .OUT_VALID(ov[2]),
    .OUT_READY(ordy[2]), .BUSY(bz[2]), .state_dbg(st2));

  // ---------------------------------------------------------------- scoreboard
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] exp_q2[$];
  int          acc_edge[3];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          go = 0;
  bit          done[3];
  bit          rnd_ordy[3];

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d: got %h, required %h (t=%0t)", name, c, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name, input int c);
    n_cmp++;
    n_bad++;
    $display("FAIL %s cfg%0d: timed out waiting on DUT (t=%0t)", name, c, $time);
  endtask

  function automatic void push_exp(input int c, input logic [63:0] v);
    case (c)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(input int c);
    case (c)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [63:0] pop_exp(input int c);
    case (c)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  // Reference: plain integer product of the (optionally sign-interpreted) operands, reduced mod 2^(2w).
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input logic s);
    longint      av, bv;
    logic [63:0] mask;
    av = longint'({32'd0, a});
    bv = longint'({32'd0, b});
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    mask = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(av * bv) & mask;
  endfunction

  function automatic logic [31:0] gen_op(input int w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0: return m;
      1: return 32'd1 << (w - 1);
      2: return 32'd0;
      3: return 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  // Monitor: pops on every output handshake and checks OUT_VALID rise latency.
  bit prev_ov[3];
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (!rst[c]) begin
          if (ov[c] && !prev_ov[c])
            chk("latency", c, 64'(cyc - acc_edge[c]), 64'(nc[c]));
          if (ov[c] && ordy[c]) begin
            if (q_size(c) == 0) timeout("unexpected_output", c);
            else chk("product", c, prod[c], pop_exp(c));
          end
        end
        prev_ov[c] = ov[c];
      end
    end
  end

  // Random OUT_READY for configurations that ask for it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++)
        if (rnd_ordy[c]) ordy[c] = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic issue(input int c, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp);
    bit ok = 1'b0;
    in1[c] = a;
    in2[c] = b;
    sm[c]  = s;
    iv[c]  = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ir[c]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout("accept", c);
      iv[c] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    push_exp(c, exp);
    acc_edge[c] = cyc;
    iv[c]  = 1'b0;
    in1[c] = $urandom;
    in2[c] = $urandom;
    sm[c]  = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_rand(input int c);
    logic [31:0] a, b;
    logic        s;
    a = gen_op(cw[c]);
    b = gen_op(cw[c]);
    s = 1'($urandom_range(0, 1));
    issue(c, a, b, s, ref_mult(a, b, cw[c], s));
  endtask

  task automatic wait_idle(input int c);
    bit ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (ir[c] && !ov[c] && q_size(c) == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("drain", c);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int c, input int n);
    rnd_ordy[c] = 1'b1;
    for (int i = 0; i < n; i++) begin
      issue_rand(c);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle(c);
    done[c] = 1'b1;
  endtask

  initial begin
    wait (go);
    rand_run(1, 1000);
  end

  initial begin
    wait (go);
    rand_run(2, 1000);
  end

  // ---------------------------------------------------------------- clock/reset + directed
  initial begin
    int          e1, hedge, lowcnt;
    bit          ok;
    logic [63:0] held;

    for (int c = 0; c < 3; c++) begin
      rst[c] = 1'b1; iv[c] = 1'b0; sm[c] = 1'b0; ordy[c] = 1'b0;
      in1[c] = '0;   in2[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) rst[c] = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk("rst_in_ready", c, 64'(ir[c]), 64'd1);
      chk("rst_out_valid", c, 64'(ov[c]), 64'd0);
      chk("rst_busy", c, 64'(bz[c]), 64'd0);
      chk("rst_output", c, prod[c], 64'd0);
    end
    chk("rst_state_idle", 0, 64'(st0), 64'd0);
    @(posedge clk);
    #1;
    go = 1'b1;
    ordy[0] = 1'b1;

    // All-ones unsigned, then count cycles with IN_READY low.
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    lowcnt = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir[0]) break;
      lowcnt++;
    end
    chk("in_ready_low_cycles", 0, 64'(lowcnt), 64'(nc[0] + 1));
    wait_idle(0);

    // Back-to-back issue interval with OUT_READY high.
    issue(0, 32'd1, 32'd2, 1'b0, 64'd2);
    e1 = acc_edge[0];
    issue(0, 32'd3, 32'd4, 1'b0, 64'd12);
    chk("issue_interval", 0, 64'(acc_edge[0] - e1), 64'(nc[0] + 2));
    wait_idle(0);

    // Signed corner products.
    issue(0, 32'hFFFF_FFFD, 32'd5,        1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    issue(0, 32'h8000_0000, 32'd1,        1'b1, 64'hFFFF_FFFF_8000_0000);
    issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
    wait_idle(0);

    // Backpressure: hold in DONE for 5 cycles with a new request pending.
    ordy[0] = 1'b0;
    issue(0, 32'd3, 32'd4, 1'b0, 64'd12);
    in1[0] = 32'd5; in2[0] = 32'd6; sm[0] = 1'b0; iv[0] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ov[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("done_wait", 0);
    held = prod[0];
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_out_valid", 0, 64'(ov[0]), 64'd1);
      chk("bp_output_stable", 0, prod[0], held);
      chk("bp_in_ready", 0, 64'(ir[0]), 64'd0);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    hedge = cyc + 1;
    issue(0, 32'd5, 32'd6, 1'b0, 64'd30);
    chk("accept_after_release", 0, 64'(acc_edge[0] - hedge), 64'd1);
    wait_idle(0);

    // Reset two digits into a calculation: product discarded, outputs back to reset values.
    issue(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 0, 64'(ov[0]), 64'd0);
    chk("midrst_output", 0, prod[0], 64'd0);
    chk("midrst_in_ready", 0, 64'(ir[0]), 64'd1);
    void'(exp_q0.pop_back());
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    issue(0, 32'd7, 32'd9, 1'b0, 64'd63);
    wait_idle(0);

    // Operands scrambled every cycle while the calculation is in flight.
    for (int r = 0; r < 3; r++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom; b = $urandom; s = 1'(r != 1);
      issue(0, a, b, s, ref_mult(a, b, 32, s));
      for (int t = 0; t < nc[0] + 1; t++) begin
        @(posedge clk);
        #1;
        in1[0] = $urandom; in2[0] = $urandom; sm[0] = 1'($urandom_range(0, 1));
      end
      wait_idle(0);
    end

    rand_run(0, 300);

    ok = 1'b0;
    for (int t = 0; t < 30000; t++) begin
      @(negedge clk);
      if (done[1] && done[2]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("random_runs", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
